reg_wb_queue: RTL and testbench

- Write-side initiator for the 32x64 register file write port (RegWrite/WN/WD).
- Buffers register write-back requests from the writeback stage and multi-cycle producers, e.g. late loads.
- Drains the queue one entry per cycle onto the register file write port, using registered outputs that are stable before the file's negedge commit.
- With the optional bypass compiled in, exposes the newest pending value per register so reads do not return stale data.

---
 rtl/reg_wb_queue.sv | 145 ++++++++++++++
 tb/tb_reg_wb_queue.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/reg_wb_queue.sv
// Register-file write-back queue: buffers write requests and drains one per cycle
// onto registered RegWrite/WN/WD. Optional bypass search: `define REG_WB_QUEUE_BYPASS_EN.
module reg_wb_queue #(
    parameter int         DEPTH = 4,
    parameter logic [4:0] XZR   = 5'd31
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_wn,
    input  logic [63:0]              in_wd,
    input  logic                     rf_hold,
    output logic                     RegWrite,
    output logic [4:0]               WN,
    output logic [63:0]              WD,
    output logic [$clog2(DEPTH):0]   count
`ifdef REG_WB_QUEUE_BYPASS_EN
    ,
    input  logic [4:0]               byp_rn1,
    input  logic [4:0]               byp_rn2,
    output logic                     byp_hit1,
    output logic                     byp_hit2,
    output logic [63:0]              byp_data1,
    output logic [63:0]              byp_data2
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [4:0]    ent_wn_q [DEPTH];
    logic [63:0]   ent_wd_q [DEPTH];
    logic [DEPTH-1:0] ent_valid_q;
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          regwrite_q, regwrite_d;
    logic [4:0]    wn_q, wn_d;
    logic [63:0]   wd_q, wd_d;
    logic          accept_s, store_s, push_s, pop_s, head_valid_s;

    assign in_ready     = (count_q < DEPTH_C);
    assign accept_s     = in_valid && in_ready;
    assign store_s      = accept_s && (in_wn != XZR);
    assign head_valid_s = ent_valid_q[rd_ptr_q];
    assign RegWrite     = regwrite_q;
    assign WN           = wn_q;
    assign WD           = wd_q;
    assign count        = count_q;

    // Drain arbitration: hold, pop head, cut-through from input, or idle.
    always_comb begin
        pop_s      = 1'b0;
        push_s     = store_s;
        regwrite_d = 1'b0;
        wn_d       = wn_q;
        wd_d       = wd_q;
        if (rf_hold) begin
            regwrite_d = 1'b0;
        end else if (head_valid_s) begin
            regwrite_d = 1'b1;
            wn_d       = ent_wn_q[rd_ptr_q];
            wd_d       = ent_wd_q[rd_ptr_q];
            pop_s      = 1'b1;
        end else if (store_s && (count_q == {CW{1'b0}})) begin
            // Empty queue: the request skips storage and goes straight to the outputs.
            regwrite_d = 1'b1;
            wn_d       = in_wn;
            wd_d       = in_wd;
            push_s     = 1'b0;
        end else begin
            regwrite_d = 1'b0;
        end
    end

    // Occupancy next-state from push/pop pair.
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    // Control state and registered write port, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q    <= {PW{1'b0}};
            wr_ptr_q    <= {PW{1'b0}};
            count_q     <= {CW{1'b0}};
            ent_valid_q <= {DEPTH{1'b0}};
            regwrite_q  <= 1'b0;
            wn_q        <= 5'd0;
            wd_q        <= 64'd0;
        end else begin
            count_q    <= count_d;
            regwrite_q <= regwrite_d;
            wn_q       <= wn_d;
            wd_q       <= wd_d;
            if (pop_s) begin
                ent_valid_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q              <= rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
            end
            if (push_s) begin
                ent_valid_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q              <= wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
            end
        end
    end

    // Entry payload storage; validity is tracked separately so no reset is needed here.
    always_ff @(posedge clk) begin
        if (rst_n && push_s) begin
            ent_wn_q[wr_ptr_q] <= in_wn;
            ent_wd_q[wr_ptr_q] <= in_wd;
        end
    end

`ifdef REG_WB_QUEUE_BYPASS_EN
    // Walks oldest to newest so the newest matching entry wins; returns {hit, data}.
    function automatic logic [64:0] byp_lookup(input logic [4:0] rn);
        logic [64:0]   res;
        logic [PW-1:0] idx;
        res = 65'd0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PW'(i);
            if (ent_valid_q[idx] && (ent_wn_q[idx] == rn) && (rn != XZR)) begin
                res = {1'b1, ent_wd_q[idx]};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Combinational read-port bypass over pending queue entries.
    always_comb begin
        {byp_hit1, byp_data1} = byp_lookup(byp_rn1);
        {byp_hit2, byp_data2} = byp_lookup(byp_rn2);
    end
`endif

endmodule

// File: tb/tb_reg_wb_queue.sv
// Scoreboard bench for reg_wb_queue: expected commits queued at issue, checked by a negedge monitor.
module tb_reg_wb_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_wn;
    logic [63:0] in_wd;
    logic        rf_hold;
    logic        RegWrite;
    logic [4:0]  WN;
    logic [63:0] WD;
    logic [2:0]  count;
`ifdef REG_WB_QUEUE_BYPASS_EN
    logic [4:0]  byp_rn1, byp_rn2;
    logic        byp_hit1, byp_hit2;
    logic [63:0] byp_data1, byp_data2;
`endif

    int checks   = 0;
    int failures = 0;
    logic [68:0] exp_q [$];
    logic [63:0] rf_model [32];

    always #5 clk = ~clk;

    reg_wb_queue #(.DEPTH(4), .XZR(5'd31)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_wn(in_wn), .in_wd(in_wd), .rf_hold(rf_hold),
        .RegWrite(RegWrite), .WN(WN), .WD(WD), .count(count)
`ifdef REG_WB_QUEUE_BYPASS_EN
        , .byp_rn1(byp_rn1), .byp_rn2(byp_rn2), .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
        .byp_data1(byp_data1), .byp_data2(byp_data2)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one request for one edge; commits are expected only for non-XZR targets.
    task automatic push(input logic [4:0] wn, input logic [63:0] wd, input bit expect_commit);
        in_valid = 1'b1;
        in_wn    = wn;
        in_wd    = wd;
        if (expect_commit) exp_q.push_back({wn, wd});
        tick();
        in_valid = 1'b0;
    endtask

    // Monitor: every RegWrite cycle must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && RegWrite === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=WN%0d/%h expected=none", WN, WD);
            end else begin
                logic [68:0] e;
                e = exp_q.pop_front();
                chk("commit_wn", {59'd0, WN}, {59'd0, e[68:64]});
                chk("commit_wd", WD, e[63:0]);
            end
            rf_model[WN] = WD;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_wn = 5'd0; in_wd = 64'd0; rf_hold = 1'b0;
`ifdef REG_WB_QUEUE_BYPASS_EN
        byp_rn1 = 5'd0; byp_rn2 = 5'd0;
`endif
        for (int i = 0; i < 32; i++) rf_model[i] = 64'd0;
        tick(); tick();
        rst_n = 1'b1;
        chk("rst_regwrite", {63'd0, RegWrite}, 64'd0);
        chk("rst_wn", {59'd0, WN}, 64'd0);
        chk("rst_wd", WD, 64'd0);
        chk("rst_count", {61'd0, count}, 64'd0);
        chk("rst_ready", {63'd0, in_ready}, 64'd1);

        // Queue three writes under hold, then reset: none may reach the file.
        rf_hold = 1'b1;
        push(5'd1, 64'h111, 1'b0);
        push(5'd2, 64'h222, 1'b0);
        push(5'd3, 64'h333, 1'b0);
        chk("pre_rst_count", {61'd0, count}, 64'd3);
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        chk("midrst_count", {61'd0, count}, 64'd0);
        chk("midrst_regwrite", {63'd0, RegWrite}, 64'd0);
        chk("midrst_wn", {59'd0, WN}, 64'd0);
        chk("midrst_wd", WD, 64'd0);
        chk("midrst_ready", {63'd0, in_ready}, 64'd1);
        rf_hold = 1'b0;
        tick(); tick(); tick();

        // Cut-through on empty queue.
        push(5'd5, 64'h1234, 1'b1);
        chk("ct_regwrite", {63'd0, RegWrite}, 64'd1);
        chk("ct_wn", {59'd0, WN}, 64'd5);
        chk("ct_wd", WD, 64'h1234);
        chk("ct_count", {61'd0, count}, 64'd0);
        tick();
        chk("ct_pulse_end", {63'd0, RegWrite}, 64'd0);
        chk("ct_rf_reg5", rf_model[5], 64'h1234);

        // Fill to full under hold, then drain in order.
        rf_hold = 1'b1;
        push(5'd1, 64'h11, 1'b1);
        push(5'd2, 64'h22, 1'b1);
        push(5'd3, 64'h33, 1'b1);
        push(5'd4, 64'h44, 1'b1);
        chk("full_count", {61'd0, count}, 64'd4);
        chk("full_ready", {63'd0, in_ready}, 64'd0);
        chk("full_regwrite", {63'd0, RegWrite}, 64'd0);
        rf_hold = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("drain_regwrite", {63'd0, RegWrite}, 64'd1);
            chk("drain_wn", {59'd0, WN}, 64'(i));
            chk("drain_count", {61'd0, count}, 64'(4 - i));
            chk("drain_ready", {63'd0, in_ready}, 64'd1);
        end
        tick();
        chk("drain_idle", {63'd0, RegWrite}, 64'd0);

        // Steady push/pop at count=2 with pointer wrap.
        rf_hold = 1'b1;
        push(5'd20, 64'hAA, 1'b1);
        push(5'd21, 64'hBB, 1'b1);
        rf_hold = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_wn    = 5'(8 + i);
            in_wd    = 64'h100 + 64'(i);
            exp_q.push_back({in_wn, in_wd});
            tick();
            chk("pp_count", {61'd0, count}, 64'd2);
            chk("pp_regwrite", {63'd0, RegWrite}, 64'd1);
        end
        in_valid = 1'b0;
        tick(); tick();
        chk("pp_empty", {61'd0, count}, 64'd0);
        tick();

        // XZR request: handshake completes but nothing is written.
        push(5'd31, 64'hFFFF, 1'b0);
        chk("xzr_regwrite", {63'd0, RegWrite}, 64'd0);
        chk("xzr_count", {61'd0, count}, 64'd0);
        tick();

`ifdef REG_WB_QUEUE_BYPASS_EN
        rf_hold = 1'b1;
        push(5'd7, 64'hA, 1'b1);
        push(5'd7, 64'hB, 1'b1);
        byp_rn1 = 5'd7; byp_rn2 = 5'd31;
        #1;
        chk("byp_hit1", {63'd0, byp_hit1}, 64'd1);
        chk("byp_data1", byp_data1, 64'hB);
        chk("byp_hit2", {63'd0, byp_hit2}, 64'd0);
        chk("byp_data2", byp_data2, 64'd0);
        rf_hold = 1'b0;
        tick(); tick(); tick();
        chk("byp_hit1_drained", {63'd0, byp_hit1}, 64'd0);
        chk("byp_data1_drained", byp_data1, 64'd0);
`endif

        tick(); tick();
        chk("all_committed", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
